// File: rtl/ball_motion_if.sv
// Signal bundle between the LCD timing / paddle logic and the pong ball controller.
// The slave side is the ball controller; the master side owns timing and paddles.
interface ball_motion_if;
    logic [9:0] hcnt;
    logic [9:0] vcnt;
    logic       de;
    logic       game_active;
    logic [8:0] paddle_L_Y;
    logic [8:0] paddle_R_Y;
    logic       draw_ball;
    logic [9:0] ball_X;
    logic [9:0] ball_Y;
    logic       score_L;
    logic       score_R;
    logic       hit;

    modport master (
        output hcnt, vcnt, de, game_active, paddle_L_Y, paddle_R_Y,
        input  draw_ball, ball_X, ball_Y, score_L, score_R, hit
    );

    modport slave (
        input  hcnt, vcnt, de, game_active, paddle_L_Y, paddle_R_Y,
        output draw_ball, ball_X, ball_Y, score_L, score_R, hit
    );
endinterface

// File: rtl/ball_motion.sv
// Pong ball controller: frame-synchronous motion, wall bounce, paddle reflection,
// scoring and serve sequencing, plus a registered ball pixel flag for the pixel mux.
module ball_motion #(
    parameter int unsigned GAME_WIDTH   = 480,
    parameter int unsigned GAME_HEIGHT  = 272,
    parameter int unsigned BALL_SIZE    = 10,
    parameter int unsigned CORR_X       = 43,
    parameter int unsigned CORR_Y       = 12,
    parameter int unsigned SPEED_X      = 2,
    parameter int unsigned SPEED_Y      = 1,
    parameter int unsigned PADDLE_W     = 6,
    parameter int unsigned PADDLE_H     = 40,
    parameter int unsigned PADDLE_L_X   = 10,
    parameter int unsigned PADDLE_R_X   = 464,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned SCORE_FRAMES = 30,
    parameter int unsigned TICK_LINE    = 285
) (
    input  logic         clk,
    input  logic         rst,
    ball_motion_if.slave bus
);
    localparam logic [10:0] CX     = 11'((GAME_WIDTH - BALL_SIZE) / 2);
    localparam logic [10:0] CY     = 11'((GAME_HEIGHT - BALL_SIZE) / 2);
    localparam logic [10:0] BS     = 11'(BALL_SIZE);
    localparam logic [10:0] SPX    = 11'(SPEED_X);
    localparam logic [10:0] SPY    = 11'(SPEED_Y);
    localparam logic [10:0] PH     = 11'(PADDLE_H);
    localparam logic [10:0] FACE_L = 11'(PADDLE_L_X + PADDLE_W);
    localparam logic [10:0] FACE_R = 11'(PADDLE_R_X);
    localparam logic [10:0] XR_HIT = 11'(PADDLE_R_X - BALL_SIZE);
    localparam logic [10:0] X_MAX  = 11'(GAME_WIDTH - BALL_SIZE);
    localparam logic [10:0] Y_MAX  = 11'(GAME_HEIGHT - BALL_SIZE);
    localparam logic [10:0] OFS_X  = 11'(CORR_X);
    localparam logic [10:0] OFS_Y  = 11'(CORR_Y);
    localparam logic [9:0]  TICK_V = 10'(TICK_LINE);

    localparam int unsigned CNT_MAX = (SERVE_FRAMES > SCORE_FRAMES) ? SERVE_FRAMES : SCORE_FRAMES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [CNT_W-1:0] SCORE_LAST = CNT_W'(SCORE_FRAMES - 1);

    typedef enum logic [1:0] {IDLE, SERVE, MOVE, SCORED} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       x_q, x_d, y_q, y_d;
    logic             dirx_q, dirx_d, diry_q, diry_d;
    logic             score_l_q, score_l_d, score_r_q, score_r_d, hit_q, hit_d;
    logic             line_q, line_dly_q, tick_q;
    logic             draw_q, draw_d;

    logic [10:0] x_w, y_w, pl_w, pr_w, nx_r, ny_d;
    logic [10:0] h_w, v_w, bx_w, by_w;
    logic        ovl_l, ovl_r, hit_l, hit_r;

    assign x_w  = {1'b0, x_q};
    assign y_w  = {1'b0, y_q};
    assign pl_w = {2'b00, bus.paddle_L_Y};
    assign pr_w = {2'b00, bus.paddle_R_Y};
    assign nx_r = x_w + SPX;
    assign ny_d = y_w + SPY;

    // Overlap uses the pre-step Y; "nx <= face" is rewritten as "x <= face+speed" to avoid underflow
    assign ovl_l = (y_w + BS > pl_w) && (y_w < pl_w + PH);
    assign ovl_r = (y_w + BS > pr_w) && (y_w < pr_w + PH);
    assign hit_l = (x_w >= FACE_L) && (x_w <= FACE_L + SPX) && ovl_l;
    assign hit_r = (x_w + BS <= FACE_R) && (x_w + BS + SPX >= FACE_R) && ovl_r;

    assign h_w    = {1'b0, bus.hcnt};
    assign v_w    = {1'b0, bus.vcnt};
    assign bx_w   = x_w + OFS_X;
    assign by_w   = y_w + OFS_Y;
    assign draw_d = bus.de && (h_w > bx_w) && (h_w <= bx_w + BS)
                           && (v_w > by_w) && (v_w <= by_w + BS);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        y_d       = y_q;
        dirx_d    = dirx_q;
        diry_d    = diry_q;
        score_l_d = 1'b0;
        score_r_d = 1'b0;
        hit_d     = 1'b0;

        if (!bus.game_active) begin
            state_d = IDLE;
            cnt_d   = '0;
            x_d     = CX[9:0];
            y_d     = CY[9:0];
            dirx_d  = 1'b1;
            diry_d  = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = SERVE;
                    cnt_d   = '0;
                    x_d     = CX[9:0];
                    y_d     = CY[9:0];
                end
                SERVE: begin
                    if (tick_q) begin
                        if (cnt_q == SERVE_LAST) begin
                            state_d = MOVE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                MOVE: begin
                    if (tick_q) begin
                        if (!dirx_q) begin
                            if (hit_l) begin
                                x_d    = FACE_L[9:0];
                                dirx_d = 1'b1;
                                hit_d  = 1'b1;
                            end else if (x_w < SPX) begin
                                score_r_d = 1'b1;
                                dirx_d    = 1'b0;
                                state_d   = SCORED;
                                cnt_d     = '0;
                            end else begin
                                x_d = x_q - SPX[9:0];
                            end
                        end else begin
                            if (hit_r) begin
                                x_d    = XR_HIT[9:0];
                                dirx_d = 1'b0;
                                hit_d  = 1'b1;
                            end else if (nx_r > X_MAX) begin
                                score_l_d = 1'b1;
                                dirx_d    = 1'b1;
                                state_d   = SCORED;
                                cnt_d     = '0;
                            end else begin
                                x_d = nx_r[9:0];
                            end
                        end

                        // Y steps independently, including on a scoring tick
                        if (diry_q) begin
                            if (ny_d >= Y_MAX) begin
                                y_d    = Y_MAX[9:0];
                                diry_d = 1'b0;
                            end else begin
                                y_d = ny_d[9:0];
                            end
                        end else begin
                            if (y_w <= SPY) begin
                                y_d    = '0;
                                diry_d = 1'b1;
                            end else begin
                                y_d = y_q - SPY[9:0];
                            end
                        end
                    end
                end
                SCORED: begin
                    if (tick_q) begin
                        if (cnt_q == SCORE_LAST) begin
                            state_d = SERVE;
                            cnt_d   = '0;
                            x_d     = CX[9:0];
                            y_d     = CY[9:0];
                            diry_d  = ~diry_q;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            x_q       <= CX[9:0];
            y_q       <= CY[9:0];
            dirx_q    <= 1'b1;
            diry_q    <= 1'b1;
            score_l_q <= 1'b0;
            score_r_q <= 1'b0;
            hit_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            dirx_q    <= dirx_d;
            diry_q    <= diry_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            hit_q     <= hit_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q     <= 1'b0;
            line_dly_q <= 1'b0;
            tick_q     <= 1'b0;
            draw_q     <= 1'b0;
        end else begin
            line_q     <= (bus.vcnt == TICK_V);
            line_dly_q <= line_q;
            tick_q     <= line_q & ~line_dly_q;
            draw_q     <= draw_d;
        end
    end

    assign bus.draw_ball = draw_q;
    assign bus.ball_X    = x_q;
    assign bus.ball_Y    = y_q;
    assign bus.score_L   = score_l_q;
    assign bus.score_R   = score_r_q;
    assign bus.hit       = hit_q;
endmodule

// File: doc/ball_motion.md
# ball_motion

Ball controller for the TFT-LCD pong game with frame-synchronous motion, wall bounce, paddle collision, scoring and serve sequencing. It sits beside the paddle controllers and scoreboard. It consumes the LCD timing counters (`hcnt`, `vcnt`, `de`) and paddle positions. It produces a registered ball pixel flag for the pixel mux, plus score and hit event pulses.

## Interface
Parameters:
- `GAME_WIDTH`, 480: playfield width, px
- `GAME_HEIGHT`, 272: playfield height, px
- `BALL_SIZE`, 10: ball edge length, px
- `CORR_X`, 43: `hcnt` offset of game column 0
- `CORR_Y`, 12: `vcnt` offset of game row 0
- `SPEED_X`, 2: px per frame, X
- `SPEED_Y`, 1: px per frame, Y
- `PADDLE_W`, 6: paddle width, px
- `PADDLE_H`, 40: paddle height, px
- `PADDLE_L_X`, 10: left paddle left column (face = `PADDLE_L_X+PADDLE_W`)
- `PADDLE_R_X`, 464: right paddle left column (face)
- `SERVE_FRAMES`, 60: frames held centred before launch
- `SCORE_FRAMES`, 30: frames ball frozen after a point
- `TICK_LINE`, 285: `vcnt` value that triggers the per-frame update (first line after vDE)

Ports:
- `clk`, in, 1: pixel clock
- `rst`, in, 1: asynchronous, active-high reset
- `hcnt`, in, 10: horizontal pixel counter
- `vcnt`, in, 10: vertical line counter
- `de`, in, 1: data-enable
- `game_active`, in, 1: level; low forces IDLE
- `paddle_L_Y`, in, 9: left paddle top row, game coordinates
- `paddle_R_Y`, in, 9: right paddle top row, game coordinates
- `draw_ball`, out, 1: registered ball pixel flag
- `ball_X`, out, 10: ball left column, game coordinates
- `ball_Y`, out, 10: ball top row, game coordinates
- `score_L`, out, 1: 1-cycle pulse; left player scored (ball exited right)
- `score_R`, out, 1: 1-cycle pulse; right player scored (ball exited left)
- `hit`, out, 1: 1-cycle pulse on any paddle reflection

## Operation
- **Centre position:** CX = (GAME_WIDTH−BALL_SIZE)/2 = 235; CY = (GAME_HEIGHT−BALL_SIZE)/2 = 131.
- **Frame tick:** registered rising edge of (`vcnt == TICK_LINE`). Exactly one cycle per frame. All motion and frame counters advance only on tick.
- **States:**
  - IDLE: ball at (CX,CY); frame counter cleared. On `game_active` = 1, go to SERVE.
  - SERVE: count SERVE_FRAMES ticks, then go to MOVE.
  - MOVE: apply one motion step per tick (rules below).
  - SCORED: position frozen. After SCORE_FRAMES ticks, recentre, toggle `dir_y`, go to SERVE.
- **game_active = 0** in any state: go to IDLE on the next clk, not tick-gated.
- **Direction registers:** `dir_x` (1 = right), `dir_y` (1 = down).
  - Reset and IDLE values: `dir_x` = 1, `dir_y` = 1.
  - After a point, serve goes toward the conceding player. After `score_R`, `dir_x` = 0; after `score_L`, `dir_x` = 1.
- **X step, moving left** (nx = x−SPEED_X, face F = PADDLE_L_X+PADDLE_W):
  - Paddle hit when x ≥ F, nx ≤ F, and `ball_Y+BALL_SIZE > paddle_L_Y` and `ball_Y < paddle_L_Y+PADDLE_H`.
  - On hit: x = F, `dir_x` = 1, `hit` pulse.
  - Else if x < SPEED_X: `score_R` pulse, go to SCORED, x unchanged.
  - Else: x = nx.
- **X step, moving right:** mirror of the left rule.
  - Face is PADDLE_R_X, tested against the ball's right edge x+BALL_SIZE.
  - Paddle Y overlap uses `paddle_R_Y`. On hit, x = PADDLE_R_X−BALL_SIZE.
  - Exit condition: x+SPEED_X > GAME_WIDTH−BALL_SIZE, which pulses `score_L`.
- **Y step:**
  - Moving down, if y+SPEED_Y ≥ GAME_HEIGHT−BALL_SIZE: y = GAME_HEIGHT−BALL_SIZE, `dir_y` = 0.
  - Moving up, if y ≤ SPEED_Y: y = 0, `dir_y` = 1.
  - Otherwise y moves by SPEED_Y.
- **Corners:** X and Y are evaluated independently on the same tick, so a corner bounce reflects both axes. The Y step is still applied on a scoring tick.
- **Arithmetic:** 11-bit intermediates; no wrap-around permitted. Paddle overlap uses the pre-step Y.
- **Draw rule:** `draw_ball` = `de` && `hcnt` > `ball_X`+CORR_X && `hcnt` ≤ `ball_X`+CORR_X+BALL_SIZE && `vcnt` > `ball_Y`+CORR_Y && `vcnt` ≤ `ball_Y`+CORR_Y+BALL_SIZE. Registered; 0 when `de` = 0.

## Timing
- **Reset values:** state IDLE, `ball_X` = 235, `ball_Y` = 131, `dir_x` = `dir_y` = 1, counters 0, `draw_ball`/`score_L`/`score_R`/`hit` = 0.
- **Tick latency:** tick asserts 2 clks after `vcnt` first equals TICK_LINE. Position and pulses update 1 clk after tick.
- **Pulses:** `score_*` and `hit` are high for exactly 1 clk. They never assert outside MOVE.
- **Draw latency:** `draw_ball` lags `hcnt`/`vcnt`/`de` by 1 clk.
- **Position stability:** position changes only during vertical blanking (TICK_LINE is outside vDE), so no tearing.
- **Reset mid-operation:** reset asserted in any state takes effect immediately and asynchronously, producing all reset values. No pulse is emitted while `rst` is high.
- **Serve timing:** SERVE entered from IDLE launches on tick SERVE_FRAMES (60th tick). From the first MOVE tick, the ball moves SPEED_X/SPEED_Y every tick.

## Test plan
- **Reset / draw:** `rst` high then low, `game_active` = 0 → `ball_X` = 235, `ball_Y` = 131. `draw_ball` = 1 exactly for `hcnt` 279..288 × `vcnt` 144..153 with `de` = 1, 1-clk lag.
- **Serve:** raise `game_active` → no motion for 60 ticks. On tick 61 (first MOVE tick), `ball_X` = 237, `ball_Y` = 132.
- **Wall bounce:** force ball moving down at y = 261 → next tick y = 262, `dir_y` = 0. Following tick y = 261.
- **Left paddle hit:** `dir_x` = 0, x = 17, `paddle_L_Y` = `ball_Y`−5 → x = 16, `dir_x` = 1, one `hit` pulse.
- **Miss and score:** same as the paddle-hit case but `paddle_L_Y` = 200, `ball_Y` = 20 → ball continues to x < 2, then `score_R` pulses once. Ball frozen 30 ticks, recentres at (235,131), serves left with `dir_y` toggled.
- **Mid-play disruptions:** `game_active` dropped mid-MOVE → IDLE and centre next clk. Async `rst` asserted mid-SCORED → reset values immediately, no `score_*`/`hit` pulses.
